float_div: RTL



---
 rtl/float_div_if.sv | 10 +
 rtl/float_div.sv | 108 ++++++++++
 2 files changed

// File: rtl/float_div_if.sv
// float_div_if: start/ready handshake and operand/result bus of the float divider
interface float_div_if;
    logic        start;
    logic [31:0] float_in_1;
    logic [31:0] float_in_2;
    logic [31:0] float_out;
    logic        ready;
    modport master (output start, float_in_1, float_in_2, input float_out, ready);
    modport slave (input start, float_in_1, float_in_2, output float_out, ready);
endinterface

// File: rtl/float_div.sv
// float_div: sequential IEEE-754 single divider, restoring mantissa division; define FLOAT_DIV_ROUND_EN for round-half-up
module float_div #(
    parameter int BIAS   = 127,
    parameter int Q_BITS = 26
) (
    input logic        clk,
    input logic        rst,
    float_div_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DIVIDE, NORMALIZE, ROUND, FINISH} state_t;
    typedef enum logic [1:0] {C_NORM, C_NAN, C_INF, C_ZERO} cls_t;
`ifdef FLOAT_DIV_ROUND_EN
    localparam logic RND = 1'b1;
`else
    localparam logic RND = 1'b0;
`endif
    state_t             state_q, state_d;
    cls_t               cls_q;
    logic [24:0]        r_q;
    logic [23:0]        d_q;
    logic [25:0]        q_q;
    logic [4:0]         cnt_q;
    logic               sign_q;
    logic signed [9:0]  e_q;
    logic [22:0]        frac_q;
    logic               guard_q;
    logic [31:0]        out_q, out_d, res;
    logic               ready_q, ready_d;
    logic               ge;
    logic [23:0]        sum;
    assign ge  = r_q >= {1'b0, d_q};
    assign sum = {1'b0, frac_q} + {23'd0, guard_q & RND};
    assign bus.float_out = out_q;
    assign bus.ready     = ready_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ready_q <= ready_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = bus.start ? DIVIDE : IDLE;
            DIVIDE:    state_d = (cnt_q == 5'(Q_BITS - 1)) ? NORMALIZE : DIVIDE;
            NORMALIZE: state_d = ROUND;
            ROUND:     state_d = FINISH;
            default:   state_d = IDLE;
        endcase
    end
    // special classes were latched at start; overflow/underflow come from the final exponent
    always_comb begin
        res = cls_q == C_NAN ? 32'h7FC0_0000 :
              cls_q == C_INF ? {sign_q, 8'hFF, 23'd0} :
              cls_q == C_ZERO ? {sign_q, 31'd0} :
              e_q >= 10'sd255 ? {sign_q, 8'hFF, 23'd0} :
              e_q <= 10'sd0 ? {sign_q, 31'd0} : {sign_q, e_q[7:0], frac_q};
        out_d   = state_q == FINISH ? res : out_q;
        ready_d = state_q == FINISH;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            e_q     <= '0;
            frac_q  <= '0;
            guard_q <= 1'b0;
            cls_q   <= C_NORM;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    r_q    <= {2'b01, bus.float_in_1[22:0]};
                    d_q    <= {1'b1, bus.float_in_2[22:0]};
                    q_q    <= '0;
                    cnt_q  <= '0;
                    sign_q <= bus.float_in_1[31] ^ bus.float_in_2[31];
                    e_q    <= {2'b00, bus.float_in_1[30:23]} - {2'b00, bus.float_in_2[30:23]};
                    cls_q  <= (&bus.float_in_1[30:23] || &bus.float_in_2[30:23]) ? C_NAN :
                              ~|bus.float_in_2[30:23] ? C_INF :
                              ~|bus.float_in_1[30:23] ? C_ZERO : C_NORM;
                end
                DIVIDE: begin
                    r_q   <= (ge ? r_q - {1'b0, d_q} : r_q) << 1;
                    q_q   <= {q_q[24:0], ge};
                    cnt_q <= cnt_q + 5'd1;
                end
                NORMALIZE: begin
                    frac_q  <= q_q[25] ? q_q[24:2] : q_q[23:1];
                    guard_q <= q_q[25] ? q_q[1] : q_q[0];
                    e_q     <= e_q + 10'(BIAS) - {9'd0, ~q_q[25]};
                end
                ROUND: begin
                    frac_q <= sum[22:0];
                    e_q    <= e_q + {9'd0, sum[23]};
                end
                default: ;
            endcase
        end
    end
endmodule
